sram_like_responder: RTL and testbench



---
 rtl/sram_like_responder.sv | 118 +++++++++++
 tb/tb_sram_like_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sram_like_responder.sv
// SRAM-like bus responder over word memory: accepts pipelined requests, answers in order after LATENCY cycles.
// Backpressure only via addr_ok (addr_stall or full queue); data_ok is a pulse the initiator cannot stall.
module sram_like_responder #(
   parameter int MEM_WORDS = 1024,
   parameter int LATENCY   = 2,
   parameter int QDEPTH    = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        addr_stall,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int QW = $clog2(QDEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [QW:0]   Q_FULL  = (QW+1)'(QDEPTH);
   localparam logic [CW-1:0] CD_INIT = CW'(LATENCY - 1);

   logic [31:0]   mem [MEM_WORDS];

   logic [31:0]   q_dat [QDEPTH];
   logic [CW-1:0] q_cd  [QDEPTH];
   logic          q_vld [QDEPTH];
   logic [QW-1:0] head;
   logic [QW-1:0] tail;
   logic [QW:0]   count;

   logic [AW-1:0] idx;
   logic [3:0]    be;
   logic          misaligned;
   logic          accept;
   logic          pop;
   logic          do_wr;
   logic [31:0]   rd_word;
   logic [31:0]   push_dat;
   logic          unused_addr;

   assign idx         = addr[AW+1:2];
   assign unused_addr = &{1'b0, addr[31:AW+2]};

   // Acceptance looks only at the registered count, so a full queue stays blocked in its pop cycle.
   assign addr_ok  = resetn && !addr_stall && (count < Q_FULL);
   assign accept   = req && addr_ok;
   assign data_ok  = resetn && (count != '0) && (q_cd[head] == '0);
   assign pop      = data_ok;
   assign rdata    = data_ok ? q_dat[head] : 32'h0;

   always_comb begin
      be         = 4'b0000;
      misaligned = 1'b0;
      case (size)
         2'd0: be = 4'b0001 << addr[1:0];
         2'd1: begin
            be         = addr[1] ? 4'b1100 : 4'b0011;
            misaligned = addr[0];
         end
         2'd2: begin
            be         = 4'b1111;
            misaligned = |addr[1:0];
         end
         default: misaligned = 1'b1;
      endcase
   end

   assign do_wr    = accept && wr && !misaligned;
   // Read sees the pre-write word because the memory update is non-blocking.
   assign rd_word  = mem[idx];
   assign push_dat = wr ? 32'h0 : rd_word;

   always_ff @(posedge clk) begin
      if (do_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            q_vld[i] <= 1'b0;
            q_cd[i]  <= '0;
            q_dat[i] <= 32'h0;
         end
      end else begin
         for (int i = 0; i < QDEPTH; i++) begin
            if (q_vld[i] && (q_cd[i] != '0)) q_cd[i] <= q_cd[i] - 1'b1;
         end
         if (pop) begin
            q_vld[head] <= 1'b0;
            head        <= head + 1'b1;
         end
         if (accept) begin
            q_vld[tail] <= 1'b1;
            q_cd[tail]  <= CD_INIT;
            q_dat[tail] <= push_dat;
            tail        <= tail + 1'b1;
         end
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench: instance a (LATENCY=2, QDEPTH=4) and instance b (LATENCY=3, QDEPTH=2).
module tb_sram_like_responder;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_a, wr_a, stall_a, aok_a, dok_a;
   logic [1:0]  size_a;
   logic [31:0] addr_a, wdata_a, rdata_a;
   logic        req_b, wr_b, stall_b, aok_b, dok_b;
   logic [1:0]  size_b;
   logic [31:0] addr_b, wdata_b, rdata_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sram_like_responder #(.MEM_WORDS(1024), .LATENCY(2), .QDEPTH(4)) dut_a (
      .clk(clk), .resetn(resetn), .req(req_a), .wr(wr_a), .size(size_a), .addr(addr_a),
      .wdata(wdata_a), .addr_stall(stall_a), .addr_ok(aok_a), .data_ok(dok_a), .rdata(rdata_a));

   sram_like_responder #(.MEM_WORDS(1024), .LATENCY(3), .QDEPTH(2)) dut_b (
      .clk(clk), .resetn(resetn), .req(req_b), .wr(wr_b), .size(size_b), .addr(addr_b),
      .wdata(wdata_b), .addr_stall(stall_b), .addr_ok(aok_b), .data_ok(dok_b), .rdata(rdata_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drv_a(input logic r, input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] d);
      req_a = r; wr_a = w; size_a = s; addr_a = a; wdata_a = d;
   endtask

   // Check instance a at the falling edge, then step past the next rising edge.
   task automatic tick_a(input string tag, input logic eaok, input logic edok, input logic [31:0] erd);
      @(negedge clk);
      chk({tag, ".addr_ok"}, {31'b0, aok_a}, {31'b0, eaok});
      chk({tag, ".data_ok"}, {31'b0, dok_a}, {31'b0, edok});
      chk({tag, ".rdata"}, rdata_a, erd);
      @(posedge clk);
      #1;
   endtask

   // req held until 8 accepted; with LATENCY=3/QDEPTH=2 acceptance runs 2-on/2-off.
   task automatic run_b(input logic w);
      int acc = 0;
      int rsp = 0;
      logic eaok, edok;
      logic [31:0] erd;
      for (int i = 0; i < 18; i++) begin
         req_b = (acc < 8); wr_b = w; size_b = 2'd2;
         addr_b = 32'h80 + 32'(4 * acc); wdata_b = 32'hB000_0000 + 32'(acc);
         @(negedge clk);
         eaok = ((i % 4) < 2);
         edok = (i >= 3) && (i <= 16) && ((i % 4) == 3 || (i % 4) == 0);
         erd  = (edok && !w) ? 32'hB000_0000 + 32'(rsp) : 32'h0;
         chk($sformatf("b%0d_c%0d.addr_ok", w, i), {31'b0, aok_b}, {31'b0, eaok});
         chk($sformatf("b%0d_c%0d.data_ok", w, i), {31'b0, dok_b}, {31'b0, edok});
         chk($sformatf("b%0d_c%0d.rdata", w, i), rdata_b, erd);
         if (edok) rsp++;
         if (req_b && eaok) acc++;
         @(posedge clk);
         #1;
      end
      req_b = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      drv_a(0, 0, 2'd0, 32'h0, 32'h0);
      stall_a = 1'b0;
      req_b = 1'b0; wr_b = 1'b0; size_b = 2'd0; addr_b = 32'h0; wdata_b = 32'h0; stall_b = 1'b0;
      #12;
      chk("rst.a.addr_ok", {31'b0, aok_a}, 32'h0);
      chk("rst.a.data_ok", {31'b0, dok_a}, 32'h0);
      chk("rst.a.rdata", rdata_a, 32'h0);
      chk("rst.b.addr_ok", {31'b0, aok_b}, 32'h0);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Latency: write then read 0x100.
      drv_a(1, 1, 2'd2, 32'h100, 32'hDEAD_BEEF); tick_a("lat_c0", 1, 0, 32'h0);
      drv_a(0, 0, 2'd0, 32'h0, 32'h0);           tick_a("lat_c1", 1, 0, 32'h0);
      tick_a("lat_c2", 1, 1, 32'h0);
      drv_a(1, 0, 2'd2, 32'h100, 32'h0);         tick_a("lat_c3", 1, 0, 32'h0);
      drv_a(0, 0, 2'd0, 32'h0, 32'h0);           tick_a("lat_c4", 1, 0, 32'h0);
      tick_a("lat_c5", 1, 1, 32'hDEAD_BEEF);
      tick_a("lat_c6", 1, 0, 32'h0);

      // Byte/half merge plus a suppressed misaligned half write.
      drv_a(1, 1, 2'd2, 32'h40, 32'h1122_3344);  tick_a("mrg_c0", 1, 0, 32'h0);
      drv_a(1, 1, 2'd0, 32'h41, 32'h0000_AA00);  tick_a("mrg_c1", 1, 0, 32'h0);
      drv_a(1, 1, 2'd1, 32'h42, 32'hBBBB_0000);  tick_a("mrg_c2", 1, 1, 32'h0);
      drv_a(1, 1, 2'd1, 32'h43, 32'hFFFF_0000);  tick_a("mrg_c3", 1, 1, 32'h0);
      drv_a(1, 0, 2'd2, 32'h40, 32'h0);          tick_a("mrg_c4", 1, 1, 32'h0);
      drv_a(0, 0, 2'd0, 32'h0, 32'h0);           tick_a("mrg_c5", 1, 1, 32'h0);
      tick_a("mrg_c6", 1, 1, 32'hBBBB_AA44);
      tick_a("mrg_c7", 1, 0, 32'h0);

      // Throughput on a: 8 back-to-back writes then 8 back-to-back reads.
      for (int i = 0; i < 10; i++) begin
         if (i < 8) drv_a(1, 1, 2'd2, 32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i));
         else       drv_a(0, 0, 2'd0, 32'h0, 32'h0);
         tick_a($sformatf("tpw_c%0d", i), 1, (i >= 2), 32'h0);
      end
      for (int i = 0; i < 11; i++) begin
         if (i < 8) drv_a(1, 0, 2'd2, 32'h200 + 32'(4 * i), 32'h0);
         else       drv_a(0, 0, 2'd0, 32'h0, 32'h0);
         tick_a($sformatf("tpr_c%0d", i), 1, (i >= 2 && i < 10),
                (i >= 2 && i < 10) ? 32'hA000_0000 + 32'(i - 2) : 32'h0);
      end

      // Throughput with backpressure on b.
      run_b(1'b1);
      run_b(1'b0);

      // Ordering: W A=1, R A, W A=2, R A back-to-back.
      drv_a(1, 1, 2'd2, 32'h300, 32'h1);         tick_a("ord_c0", 1, 0, 32'h0);
      drv_a(1, 0, 2'd2, 32'h300, 32'h0);         tick_a("ord_c1", 1, 0, 32'h0);
      drv_a(1, 1, 2'd2, 32'h300, 32'h2);         tick_a("ord_c2", 1, 1, 32'h0);
      drv_a(1, 0, 2'd2, 32'h300, 32'h0);         tick_a("ord_c3", 1, 1, 32'h1);
      drv_a(0, 0, 2'd0, 32'h0, 32'h0);           tick_a("ord_c4", 1, 1, 32'h0);
      tick_a("ord_c5", 1, 1, 32'h2);
      tick_a("ord_c6", 1, 0, 32'h0);

      // addr_stall for 3 cycles with req held; queued response still arrives.
      drv_a(1, 0, 2'd2, 32'h100, 32'h0);         tick_a("stl_c0", 1, 0, 32'h0);
      drv_a(1, 0, 2'd2, 32'h40, 32'h0);
      stall_a = 1'b1;                            tick_a("stl_c1", 0, 0, 32'h0);
      tick_a("stl_c2", 0, 1, 32'hDEAD_BEEF);
      tick_a("stl_c3", 0, 0, 32'h0);
      stall_a = 1'b0;                            tick_a("stl_c4", 1, 0, 32'h0);
      drv_a(0, 0, 2'd0, 32'h0, 32'h0);           tick_a("stl_c5", 1, 0, 32'h0);
      tick_a("stl_c6", 1, 1, 32'hBBBB_AA44);
      tick_a("stl_c7", 1, 0, 32'h0);

      // Reset mid-operation with reads outstanding.
      drv_a(1, 0, 2'd2, 32'h200, 32'h0);         tick_a("rmo_c0", 1, 0, 32'h0);
      drv_a(1, 0, 2'd2, 32'h204, 32'h0);         tick_a("rmo_c1", 1, 0, 32'h0);
      drv_a(1, 0, 2'd2, 32'h208, 32'h0);
      #2;
      chk("rmo_pre.data_ok", {31'b0, dok_a}, 32'h1);
      resetn = 1'b0;
      #1;
      chk("rmo_low.addr_ok", {31'b0, aok_a}, 32'h0);
      chk("rmo_low.data_ok", {31'b0, dok_a}, 32'h0);
      chk("rmo_low.rdata", rdata_a, 32'h0);
      @(posedge clk);
      #1;
      chk("rmo_hold.data_ok", {31'b0, dok_a}, 32'h0);
      drv_a(0, 0, 2'd0, 32'h0, 32'h0);
      #2;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) tick_a($sformatf("rmo_post_c%0d", i), 1, 0, 32'h0);
      drv_a(1, 0, 2'd2, 32'h100, 32'h0);         tick_a("rmo_mem_c0", 1, 0, 32'h0);
      drv_a(0, 0, 2'd0, 32'h0, 32'h0);           tick_a("rmo_mem_c1", 1, 0, 32'h0);
      tick_a("rmo_mem_c2", 1, 1, 32'hDEAD_BEEF);
      tick_a("rmo_mem_c3", 1, 0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
